ssd_scan_ctrl: RTL and testbench
================================

SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: digit count, legal range 1..8.
REQ-002 Parameter DIV, default 100000: clocks per digit slot, legal minimum 2.
REQ-003 Parameter BLINK_FRAMES, default 64: scan frames per blink half-period, legal minimum 1.
REQ-004 Port clock  input  1  rising-edge clock.
REQ-005 Port reset  input  1  reset, asynchronous, active-low.
REQ-006 Port src_sel  input  1  1 selects value_a, 0 selects value_b.
REQ-007 Port value_a  input  4*NUM_DIGITS  hex nibbles; bits [3:0] are digit 0, the rightmost digit.
REQ-008 Port value_b  input  4*NUM_DIGITS  alternate source, same packing as value_a.
REQ-009 Port load  input  1  single-cycle strobe that captures the selected source.
REQ-010 Port blank_lz  input  1  enables leading-zero blanking.
REQ-011 Port blink_en  input  1  enables whole-display blinking.
REQ-012 Port dp_mask  input  NUM_DIGITS  decimal point enable per digit.
REQ-013 Port digit_select  output  NUM_DIGITS  active-low, one-hot-low anode drive.
REQ-014 Port seg  output  7  active-low cathodes, ordered {g,f,e,d,c,b,a}.
REQ-015 Port dp  output  1  active-low decimal point.
REQ-016 Port frame_done  output  1  one-cycle pulse each time a scan frame completes.

Function
REQ-017 The prescaler SHALL count 0..DIV-1 and wrap, asserting an internal tick when the count equals DIV-1.
REQ-018 On each tick, the digit index SHALL advance by 1 and wrap from NUM_DIGITS-1 to 0; a tick at index NUM_DIGITS-1 is the wrap event.
REQ-019 On load, the selected source SHALL be captured into a pending register and a pending flag SHALL be set; a later load before the wrap event overwrites the pending value (last load wins).
REQ-020 On the wrap event edge, if the pending flag is set, the pending value SHALL be copied to the display shadow and the flag cleared; the shadow SHALL change only at this point (no mid-frame tearing).
REQ-021 If load coincides with the wrap event, the newly captured value SHALL go directly to the shadow and the pending flag SHALL end clear.
REQ-022 frame_done SHALL be high for exactly the one cycle following each wrap event edge.
REQ-023 digit_select, seg and dp SHALL be registered and SHALL reflect the index and shadow of the previous cycle (1-clock latency).
REQ-024 digit_select SHALL drive bit[index] low and all other bits high.
REQ-025 seg SHALL use the standard hex decode, active-low: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
REQ-026 When blank_lz=1, seg SHALL be 7'h7F for every digit whose nibble and all higher nibbles are zero; digit 0 is never blanked, so a zero value shows "0".
REQ-027 dp SHALL be low when dp_mask[index]=1, regardless of leading-zero blanking.
REQ-028 The blink counter SHALL count frames and toggle the blink phase every BLINK_FRAMES wrap events.
REQ-029 While blink_en=1 and the blink phase is off, digit_select SHALL be all ones and dp SHALL be 1.
REQ-030 While blink_en=0, the display SHALL always be on; the blink counter keeps running.
REQ-031 Changes to src_sel, value_a or value_b without load SHALL have no effect on the outputs.

Reset
REQ-032 When reset=0, the block SHALL immediately and asynchronously force the following values:
- prescaler, index, blink counter and blink phase: 0, phase on
- shadow, pending value and pending flag: 0
- digit_select: all ones
- seg: 7'h7F
- dp: 1
- frame_done: 0
REQ-033 After reset is released, the first clock edge SHALL start scanning at index 0 with shadow 0.
REQ-034 Reset asserted mid-frame SHALL discard any pending load.

Verification (NUM_DIGITS=4, DIV=4, BLINK_FRAMES=2)
REQ-035 The bench SHALL cover the following directed scenarios:
- Reset, then release -> digit_select=4'b1111, seg=7'h7F, dp=1 until the first edge; then digit 0 shows 7'h40.
- load with value_a=16'h1234, src_sel=1, mid-frame -> old digits kept until frame_done; next frame shows 7'h19, 7'h30, 7'h24, 7'h79 on 1110, 1101, 1011, 0111.
- blank_lz=1 with 16'h0005 loaded -> digits 3..1 show 7'h7F and digit 0 shows 7'h12; with 16'h0000 loaded, digit 0 shows 7'h40.
- load on the wrap-event cycle, followed by a second load one cycle later -> the first value is shown next frame and the second value the frame after.
- blink_en=1 -> digit_select=4'b1111 for frames 3-4, scanning in frames 5-6, and so on; frame_done fires every 16 clocks.
- reset pulsed mid-frame with a load pending -> outputs forced to reset values immediately; after release, 0 is shown and the pending value is lost.

Source files
------------

// File: rtl/ssd_scan_if.sv
// ssd_scan_if -- bundle of the source, load, option and drive signals of the
// seven-segment scan controller.
//   master : the side that supplies values/options and observes the drive pins
//   slave  : the scan controller itself
// Signals:
//   src_sel              1 picks value_a, 0 picks value_b
//   value_a, value_b     hex nibbles, bits [3:0] are digit 0 (rightmost)
//   load                 single-cycle capture strobe
//   blank_lz, blink_en   display options
//   dp_mask              per-digit decimal point enable
//   digit_select         active-low anode drive
//   seg                  active-low cathodes {g,f,e,d,c,b,a}
//   dp                   active-low decimal point
//   frame_done           one-cycle pulse per completed frame
interface ssd_scan_if #(
  parameter int NUM_DIGITS = 4
) ();
  logic                    src_sel;
  logic [4*NUM_DIGITS-1:0] value_a;
  logic [4*NUM_DIGITS-1:0] value_b;
  logic                    load;
  logic                    blank_lz;
  logic                    blink_en;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   digit_select;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_done;

  modport master (
    output src_sel, value_a, value_b, load, blank_lz, blink_en, dp_mask,
    input  digit_select, seg, dp, frame_done
  );

  modport slave (
    input  src_sel, value_a, value_b, load, blank_lz, blink_en, dp_mask,
    output digit_select, seg, dp, frame_done
  );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl -- multiplexed seven-segment display scanner.
// A prescaler divides clock down to one digit slot every DIV clocks; the digit
// index walks 0..NUM_DIGITS-1. Loaded values wait in a pending register and
// only reach the display shadow at the end of a frame, so a frame is never
// drawn from two different values. Optional leading-zero blanking and a
// frame-counted blink are applied on the registered drive outputs.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-low
//   bus    ssd_scan_if slave modport (source values, options, drive pins)
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV          = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input logic       clock,
  input logic       reset,
  ssd_scan_if.slave bus
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] LAST_PRE = PW'(DIV - 1);
  localparam logic [BW-1:0] LAST_BLK = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [VW-1:0]         shadow;
  logic [VW-1:0]         pend_val;
  logic                  pend_flag;
  logic [BW-1:0]         blink_cnt;
  logic                  blink_on;
  logic [NUM_DIGITS-1:0] digit_sel_q;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic                  frame_done_q;

  logic                  tick;
  logic                  wrap;
  logic [VW-1:0]         captured;
  logic [3:0]            nibble;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  blank;
  logic                  show;
  logic [NUM_DIGITS-1:0] onehot;
  logic                  hz;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    tick     = (presc == LAST_PRE);
    wrap     = tick && (idx == LAST_IDX);
    captured = bus.src_sel ? bus.value_a : bus.value_b;
    nibble   = shadow[idx*4 +: 4];
    onehot   = NUM_DIGITS'(1) << idx;
    // lead_zero[i]: nibble i and every nibble above it are zero
    hz        = 1'b1;
    lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      hz           = hz & (shadow[4*i +: 4] == 4'h0);
      lead_zero[i] = hz;
    end
    // digit 0 is never blanked so an all-zero value still reads "0"
    blank = bus.blank_lz && lead_zero[idx] && (idx != '0);
    show  = !bus.blink_en || blink_on;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc        <= '0;
      idx          <= '0;
      shadow       <= '0;
      pend_val     <= '0;
      pend_flag    <= 1'b0;
      blink_cnt    <= '0;
      blink_on     <= 1'b1;
      digit_sel_q  <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick)
        idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);

      if (bus.load)
        pend_val <= captured;

      // Shadow only moves at the frame boundary; a load landing exactly on
      // the boundary bypasses the pending stage.
      if (wrap) begin
        if (bus.load) begin
          shadow    <= captured;
          pend_flag <= 1'b0;
        end else if (pend_flag) begin
          shadow    <= pend_val;
          pend_flag <= 1'b0;
        end
      end else if (bus.load) begin
        pend_flag <= 1'b1;
      end

      frame_done_q <= wrap;

      if (wrap) begin
        if (blink_cnt == LAST_BLK) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end

      digit_sel_q <= show ? ~onehot : '1;
      seg_q       <= blank ? 7'h7F : hex7(nibble);
      dp_q        <= show ? ~bus.dp_mask[idx] : 1'b1;
    end
  end

  assign bus.digit_select = digit_sel_q;
  assign bus.seg          = seg_q;
  assign bus.dp           = dp_q;
  assign bus.frame_done   = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
module tb_ssd_scan_ctrl;

  logic clock;
  logic reset;
  int   tests;
  int   failed;

  ssd_scan_if #(.NUM_DIGITS(4)) bus ();

  ssd_scan_ctrl #(
    .NUM_DIGITS  (4),
    .DIV         (4),
    .BLINK_FRAMES(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic            src_sel;
    logic [15:0]     a;
    logic [15:0]     b;
    logic            blz;
    logic [3:0]      dpm;
    logic [3:0][6:0] seg;   // expected seg for digits 3..0
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_frame_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.frame_done && n < 40);
    if (!bus.frame_done) begin
      tests++;
      failed++;
      $display("FAIL %s frame_done timeout: got 0 expected 1", tag);
    end
  endtask

  // Called on the negedge where frame_done is high; checks all four digit
  // slots of the frame that has just started.
  task automatic check_frame(input string tag, input logic [3:0][6:0] segs,
                             input logic blz, input logic [3:0] dpm);
    logic [3:0] ds_exp;
    logic       dp_exp;
    bus.blank_lz = blz;
    bus.dp_mask  = dpm;
    for (int d = 0; d < 4; d++) begin
      repeat ((d == 0) ? 1 : 4) @(negedge clock);
      bus.load = 1'b0;
      ds_exp = 4'b0001 << d;
      ds_exp = ~ds_exp;
      dp_exp = ~dpm[d];
      chk($sformatf("%s d%0d digit_select", tag, d), 32'(bus.digit_select), 32'(ds_exp));
      chk($sformatf("%s d%0d seg", tag, d), 32'(bus.seg), 32'(segs[d]));
      chk($sformatf("%s d%0d dp", tag, d), 32'(bus.dp), 32'(dp_exp));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " digit_select"}, 32'(bus.digit_select), 32'h0000000F);
    chk({tag, " seg"}, 32'(bus.seg), 32'h7F);
    chk({tag, " dp"}, 32'(bus.dp), 32'h1);
    chk({tag, " frame_done"}, 32'(bus.frame_done), 32'h0);
  endtask

  logic [3:0][6:0] prev_seg;

  initial begin
    tests  = 0;
    failed = 0;
    //          sel  value_a   value_b   blz  dpm      d3     d2     d1     d0
    vecs[0] = '{1'b1, 16'h1234, 16'hFFFF, 1'b0, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{1'b0, 16'h1111, 16'hABCD, 1'b0, 4'b0101, {7'h08, 7'h03, 7'h46, 7'h21}};
    vecs[2] = '{1'b1, 16'h0005, 16'h0000, 1'b1, 4'b1000, {7'h7F, 7'h7F, 7'h7F, 7'h12}};
    vecs[3] = '{1'b1, 16'h0000, 16'h1234, 1'b1, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[4] = '{1'b0, 16'h8888, 16'h0E70, 1'b1, 4'b0010, {7'h7F, 7'h06, 7'h78, 7'h40}};
    vecs[5] = '{1'b1, 16'h9876, 16'h0000, 1'b0, 4'b1111, {7'h10, 7'h00, 7'h78, 7'h02}};
    vecs[6] = '{1'b0, 16'h5555, 16'hF0F0, 1'b1, 4'b0000, {7'h0E, 7'h40, 7'h0E, 7'h40}};
    vecs[7] = '{1'b1, 16'h0005, 16'h0000, 1'b0, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h12}};

    reset        = 1'b0;
    bus.src_sel  = 1'b0;
    bus.value_a  = '0;
    bus.value_b  = '0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;
    bus.blink_en = 1'b0;
    bus.dp_mask  = '0;

    // reset and release
    repeat (2) @(negedge clock);
    check_reset_vals("in_reset");
    reset = 1'b1;
    #1;
    check_reset_vals("after_release");
    @(negedge clock);
    chk("first_edge digit_select", 32'(bus.digit_select), 32'hE);
    chk("first_edge seg", 32'(bus.seg), 32'h40);

    // table: load mid-frame, disturb sources, check next frame
    prev_seg = {7'h40, 7'h40, 7'h40, 7'h40};
    for (int i = 0; i < 8; i++) begin
      wait_frame_done($sformatf("vec%0d", i));
      @(negedge clock);
      bus.src_sel = vecs[i].src_sel;
      bus.value_a = vecs[i].a;
      bus.value_b = vecs[i].b;
      bus.load    = 1'b1;
      @(negedge clock);
      bus.load    = 1'b0;
      bus.src_sel = ~vecs[i].src_sel;
      bus.value_a = ~vecs[i].a;
      bus.value_b = ~vecs[i].b;
      repeat (4) @(negedge clock);
      chk($sformatf("vec%0d midframe digit_select", i), 32'(bus.digit_select), 32'hD);
      chk($sformatf("vec%0d midframe old seg", i), 32'(bus.seg), 32'(prev_seg[1]));
      wait_frame_done($sformatf("vec%0d", i));
      check_frame($sformatf("vec%0d", i), vecs[i].seg, vecs[i].blz, vecs[i].dpm);
      prev_seg = vecs[i].seg;
    end

    // load on the wrap-event cycle, then another load one cycle later
    wait_frame_done("wrap");
    repeat (15) @(negedge clock);
    bus.src_sel = 1'b1;
    bus.value_a = 16'hC0DE;
    bus.load    = 1'b1;
    @(negedge clock);
    chk("wrap frame_done", 32'(bus.frame_done), 32'h1);
    bus.value_a = 16'h4321;
    check_frame("wrap_first", {7'h46, 7'h40, 7'h21, 7'h06}, 1'b0, 4'b0000);
    bus.value_a = 16'hFFFF;
    wait_frame_done("wrap_second");
    check_frame("wrap_second", {7'h19, 7'h30, 7'h24, 7'h79}, 1'b0, 4'b0000);

    // reset mid-frame with a load pending
    wait_frame_done("midreset");
    repeat (3) @(negedge clock);
    bus.value_a = 16'h5678;
    bus.load    = 1'b1;
    @(negedge clock);
    bus.load = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check_reset_vals("midreset_async");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midreset first digit_select", 32'(bus.digit_select), 32'hE);
    chk("midreset first seg", 32'(bus.seg), 32'h40);
    wait_frame_done("midreset");
    check_frame("midreset_lost", {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0, 4'b0000);

    // blink: phase on for frames 1-2, off for 3-4, on for 5-6
    @(negedge clock);
    reset        = 1'b0;
    bus.blink_en = 1'b1;
    bus.dp_mask  = 4'hF;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 96; k++) begin
      logic       on;
      logic [3:0] ds_exp;
      @(negedge clock);
      on = (((k - 1) / 32) % 2) == 0;
      ds_exp = 4'b0001 << (((k - 1) / 4) % 4);
      ds_exp = on ? ~ds_exp : 4'hF;
      chk($sformatf("blink k%0d digit_select", k), 32'(bus.digit_select), 32'(ds_exp));
      chk($sformatf("blink k%0d dp", k), 32'(bus.dp), on ? 32'h0 : 32'h1);
      chk($sformatf("blink k%0d frame_done", k), 32'(bus.frame_done),
          (k % 16 == 0) ? 32'h1 : 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
